// File: rtl/sbp_update_arbiter.sv
// sbp_update_arbiter: shares the lookup core's single lookup/update port
// between a lookup requester and a buffered table-update requester.
// Updates wait in a FIFO and take idle slots; a starvation guard forces a
// bubble once the head has waited MAX_WAIT cycles. Result strobes are
// re-timed by LATENCY-deep shift registers matching the core pipeline.
// Optional statistics counters are built when SBP_ARB_STATS_EN is defined.
module sbp_update_arbiter #(
    parameter int unsigned STAGE_ID_BITS = 6,
    parameter int unsigned LOCATION_BITS = 11,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned MAX_WAIT      = 64,
    parameter int unsigned LATENCY       = 33
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lkp_valid_i,
    output logic                          lkp_ready_o,
    input  logic [31:0]                   lkp_ip_addr_i,
    input  logic                          upd_valid_i,
    output logic                          upd_ready_o,
    input  logic [31:0]                   upd_ip_addr_i,
    input  logic [5:0]                    upd_length_i,
    input  logic [STAGE_ID_BITS-1:0]      upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0]      upd_location_i,
    input  logic [STAGE_ID_BITS-1:0]      upd_childs_stage_id_i,
    input  logic [LOCATION_BITS-1:0]      upd_childs_location_i,
    input  logic [1:0]                    upd_childs_lr_i,
    output logic                          lookup_o,
    output logic                          upd_o,
    output logic [31:0]                   ip_addr_o,
    output logic [5:0]                    upd_length_o,
    output logic [STAGE_ID_BITS-1:0]      upd_stage_id_o,
    output logic [LOCATION_BITS-1:0]      upd_location_o,
    output logic [STAGE_ID_BITS-1:0]      upd_childs_stage_id_o,
    output logic [LOCATION_BITS-1:0]      upd_childs_location_o,
    output logic [1:0]                    upd_childs_lr_o,
    output logic                          res_valid_o,
    output logic                          upd_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [31:0]                   stat_lookups_o,
    output logic [31:0]                   stat_updates_o,
    output logic [31:0]                   stat_forced_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [31:0]              ip;
        logic [5:0]               len;
        logic [STAGE_ID_BITS-1:0] stage;
        logic [LOCATION_BITS-1:0] loc;
        logic [STAGE_ID_BITS-1:0] cstage;
        logic [LOCATION_BITS-1:0] cloc;
        logic [1:0]               lr;
    } upd_entry_t;

    upd_entry_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_lookup;
    logic               r_upd;
    upd_entry_t         r_out;
    logic [LATENCY-1:0] r_lkp_sr;
    logic [LATENCY-1:0] r_upd_sr;

    logic       w_full;
    logic       w_empty;
    logic       w_force;
    logic       w_push;
    logic       w_pop;
    logic       w_lkp_fire;
    upd_entry_t w_in;
    upd_entry_t w_head;

    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_force     = (r_wait == WAIT_W'(MAX_WAIT));
    assign lkp_ready_o = rst & ~w_force;
    assign upd_ready_o = rst & ~w_full;
    assign w_push      = upd_valid_i & upd_ready_o;
    assign w_lkp_fire  = lkp_valid_i & lkp_ready_o;
    assign w_pop       = ~w_lkp_fire & ~w_empty;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_in = '{ip: upd_ip_addr_i, len: upd_length_i, stage: upd_stage_id_i,
                    loc: upd_location_i, cstage: upd_childs_stage_id_i,
                    cloc: upd_childs_location_i, lr: upd_childs_lr_i};

    // FIFO storage: data only, validity is tracked by the pointers/level
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
        end
    end

    // Starvation guard: count cycles a queued head goes unserved
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (w_pop || w_empty) begin
            r_wait <= '0;
        end else if (!w_force) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Issue decision: lookup first, else pop an update, else idle slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lookup <= 1'b0;
            r_upd    <= 1'b0;
            r_out    <= '0;
        end else if (w_lkp_fire) begin
            r_lookup <= 1'b1;
            r_upd    <= 1'b0;
            r_out    <= '0;
            r_out.ip <= lkp_ip_addr_i;
        end else if (w_pop) begin
            r_lookup <= 1'b0;
            r_upd    <= 1'b1;
            r_out    <= w_head;
        end else begin
            r_lookup <= 1'b0;
            r_upd    <= 1'b0;
            r_out    <= '0;
        end
    end

    // Latency alignment of lookup/update strobes to the core output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lkp_sr <= '0;
            r_upd_sr <= '0;
        end else begin
            r_lkp_sr[0] <= r_lookup;
            r_upd_sr[0] <= r_upd;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_lkp_sr[i] <= r_lkp_sr[i-1];
                r_upd_sr[i] <= r_upd_sr[i-1];
            end
        end
    end

    assign lookup_o              = r_lookup;
    assign upd_o                 = r_upd;
    assign ip_addr_o             = r_out.ip;
    assign upd_length_o          = r_out.len;
    assign upd_stage_id_o        = r_out.stage;
    assign upd_location_o        = r_out.loc;
    assign upd_childs_stage_id_o = r_out.cstage;
    assign upd_childs_location_o = r_out.cloc;
    assign upd_childs_lr_o       = r_out.lr;
    assign res_valid_o           = r_lkp_sr[LATENCY-1];
    assign upd_done_o            = r_upd_sr[LATENCY-1];
    assign fifo_level_o          = r_level;

`ifdef SBP_ARB_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_forced;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_lookups <= '0;
            r_stat_updates <= '0;
            r_stat_forced  <= '0;
        end else begin
            if (r_lookup && r_stat_lookups != '1) r_stat_lookups <= r_stat_lookups + 32'd1;
            if (r_upd && r_stat_updates != '1)    r_stat_updates <= r_stat_updates + 32'd1;
            if (w_force && lkp_valid_i && r_stat_forced != '1)
                r_stat_forced <= r_stat_forced + 32'd1;
        end
    end

    assign stat_lookups_o = r_stat_lookups;
    assign stat_updates_o = r_stat_updates;
    assign stat_forced_o  = r_stat_forced;
`else
    assign stat_lookups_o = '0;
    assign stat_updates_o = '0;
    assign stat_forced_o  = '0;
`endif

endmodule

// File: tb/tb_sbp_update_arbiter.sv
// Testbench for sbp_update_arbiter: directed phases with randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_sbp_update_arbiter;

    localparam int unsigned SB    = 6;
    localparam int unsigned LB    = 11;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MW    = 4;
    localparam int unsigned LAT   = 33;
    localparam int unsigned LVW   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [5:0]    len;
        logic [SB-1:0] st;
        logic [LB-1:0] loc;
        logic [SB-1:0] cst;
        logic [LB-1:0] cloc;
        logic [1:0]    lr;
    } fld_t;

    typedef struct packed {
        logic [31:0] ip;
        fld_t        f;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            lkp_valid_i = 1'b0;
    logic            lkp_ready_o;
    logic [31:0]     lkp_ip_addr_i = '0;
    logic            upd_valid_i = 1'b0;
    logic            upd_ready_o;
    logic [31:0]     upd_ip_addr_i = '0;
    logic [5:0]      upd_length_i = '0;
    logic [SB-1:0]   upd_stage_id_i = '0;
    logic [LB-1:0]   upd_location_i = '0;
    logic [SB-1:0]   upd_childs_stage_id_i = '0;
    logic [LB-1:0]   upd_childs_location_i = '0;
    logic [1:0]      upd_childs_lr_i = '0;
    logic            lookup_o, upd_o;
    logic [31:0]     ip_addr_o;
    logic [5:0]      upd_length_o;
    logic [SB-1:0]   upd_stage_id_o, upd_childs_stage_id_o;
    logic [LB-1:0]   upd_location_o, upd_childs_location_o;
    logic [1:0]      upd_childs_lr_o;
    logic            res_valid_o, upd_done_o;
    logic [LVW-1:0]  fifo_level_o;
    logic [31:0]     stat_lookups_o, stat_updates_o, stat_forced_o;

    sbp_update_arbiter #(
        .STAGE_ID_BITS(SB), .LOCATION_BITS(LB), .FIFO_DEPTH(DEPTH),
        .MAX_WAIT(MW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_ip_addr_i(lkp_ip_addr_i),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_ip_addr_i(upd_ip_addr_i),
        .upd_length_i(upd_length_i), .upd_stage_id_i(upd_stage_id_i),
        .upd_location_i(upd_location_i), .upd_childs_stage_id_i(upd_childs_stage_id_i),
        .upd_childs_location_i(upd_childs_location_i), .upd_childs_lr_i(upd_childs_lr_i),
        .lookup_o(lookup_o), .upd_o(upd_o), .ip_addr_o(ip_addr_o),
        .upd_length_o(upd_length_o), .upd_stage_id_o(upd_stage_id_o),
        .upd_location_o(upd_location_o), .upd_childs_stage_id_o(upd_childs_stage_id_o),
        .upd_childs_location_o(upd_childs_location_o), .upd_childs_lr_o(upd_childs_lr_o),
        .res_valid_o(res_valid_o), .upd_done_o(upd_done_o), .fifo_level_o(fifo_level_o),
        .stat_lookups_o(stat_lookups_o), .stat_updates_o(stat_updates_o),
        .stat_forced_o(stat_forced_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    upd_t        q[$];
    int unsigned head_wait;
    bit          m_lookup, m_upd, m_res, m_done;
    logic [31:0] m_ip;
    fld_t        m_f;
    bit          lk_hist[$], up_hist[$];
    logic [31:0] m_sl, m_su, m_sf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_wait = 0;
        m_lookup = 0; m_upd = 0; m_res = 0; m_done = 0;
        m_ip = '0; m_f = '0;
        m_sl = '0; m_su = '0; m_sf = '0;
        lk_hist.delete(); up_hist.delete();
        repeat (LAT) begin lk_hist.push_back(1'b0); up_hist.push_back(1'b0); end
    endtask

    // One clock of the arbitration rules, applied to the inputs just sampled
    task automatic model_step();
        bit   forced, fire, pop, was_empty, room;
        upd_t h;
        forced    = (head_wait == MW);
        was_empty = (q.size() == 0);
        room      = (q.size() < DEPTH);
        if (m_lookup && m_sl != 32'hFFFF_FFFF) m_sl++;
        if (m_upd && m_su != 32'hFFFF_FFFF) m_su++;
        if (forced && lkp_valid_i && m_sf != 32'hFFFF_FFFF) m_sf++;
        fire = lkp_valid_i && !forced;
        pop  = !fire && !was_empty;
        if (fire) begin
            m_lookup = 1; m_upd = 0; m_ip = lkp_ip_addr_i; m_f = '0;
        end else if (pop) begin
            h = q.pop_front();
            m_lookup = 0; m_upd = 1; m_ip = h.ip; m_f = h.f;
        end else begin
            m_lookup = 0; m_upd = 0; m_ip = '0; m_f = '0;
        end
        if (pop || was_empty) head_wait = 0;
        else if (head_wait < MW) head_wait++;
        if (upd_valid_i && room)
            q.push_back('{ip: upd_ip_addr_i, f: '{len: upd_length_i, st: upd_stage_id_i,
                          loc: upd_location_i, cst: upd_childs_stage_id_i,
                          cloc: upd_childs_location_i, lr: upd_childs_lr_i}});
        lk_hist.push_back(m_lookup); m_res  = lk_hist.pop_front();
        up_hist.push_back(m_upd);    m_done = up_hist.pop_front();
    endtask

    task automatic check_regs();
        fld_t got_f;
        got_f = '{len: upd_length_o, st: upd_stage_id_o, loc: upd_location_o,
                  cst: upd_childs_stage_id_o, cloc: upd_childs_location_o, lr: upd_childs_lr_o};
        chk("lookup_o",     64'(lookup_o), 64'(m_lookup));
        chk("upd_o",        64'(upd_o), 64'(m_upd));
        chk("exclusive",    64'(lookup_o & upd_o), 64'(0));
        chk("ip_addr_o",    64'(ip_addr_o), 64'(m_ip));
        chk("upd_fields",   64'(got_f), 64'(m_f));
        chk("res_valid_o",  64'(res_valid_o), 64'(m_res));
        chk("upd_done_o",   64'(upd_done_o), 64'(m_done));
        chk("fifo_level_o", 64'(fifo_level_o), 64'(q.size()));
`ifdef SBP_ARB_STATS_EN
        chk("stat_lookups", 64'(stat_lookups_o), 64'(m_sl));
        chk("stat_updates", 64'(stat_updates_o), 64'(m_su));
        chk("stat_forced",  64'(stat_forced_o), 64'(m_sf));
`else
        chk("stat_lookups", 64'(stat_lookups_o), 64'(0));
        chk("stat_updates", 64'(stat_updates_o), 64'(0));
        chk("stat_forced",  64'(stat_forced_o), 64'(0));
`endif
    endtask

    task automatic check_readies(input bit in_reset);
        chk("lkp_ready_o", 64'(lkp_ready_o), 64'(!in_reset && head_wait != MW));
        chk("upd_ready_o", 64'(upd_ready_o), 64'(!in_reset && q.size() < DEPTH));
    endtask

    function automatic upd_t rnd_upd();
        upd_t        u;
        logic [31:0] a, b;
        a = $urandom(); b = $urandom();
        u.ip     = $urandom();
        u.f.len  = a[5:0];
        u.f.st   = a[11:6];
        u.f.loc  = a[22:12];
        u.f.cst  = b[5:0];
        u.f.cloc = b[16:6];
        u.f.lr   = b[18:17];
        return u;
    endfunction

    task automatic cycle(input bit lv, input logic [31:0] la, input bit uv, input upd_t u);
        @(negedge clk);
        check_regs();
        lkp_valid_i           = lv;
        lkp_ip_addr_i         = la;
        upd_valid_i           = uv;
        upd_ip_addr_i         = u.ip;
        upd_length_i          = u.f.len;
        upd_stage_id_i        = u.f.st;
        upd_location_i        = u.f.loc;
        upd_childs_stage_id_i = u.f.cst;
        upd_childs_location_i = u.f.cloc;
        upd_childs_lr_i       = u.f.lr;
        #1;
        check_readies(1'b0);
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, $urandom(), 1'b0, rnd_upd());
    endtask

    task automatic release_reset();
        @(negedge clk);
        lkp_valid_i = 1'b0;
        upd_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        upd_t u;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check_readies(1'b1);
        release_reset();
        idle(4);

        // Single lookup, result strobe LAT cycles after lookup_o
        cycle(1'b1, 32'h0A00_0001, 1'b0, rnd_upd());
        idle(LAT + 3);

        // Single update with no competing lookups
        u.ip = 32'hC0A8_0000;
        u.f  = '{len: 6'd24, st: 6'd3, loc: 11'd5, cst: 6'd7, cloc: 11'd9, lr: 2'd2};
        cycle(1'b0, $urandom(), 1'b1, u);
        idle(LAT + 3);

        // Saturated lookups with one queued update: forced bubble
        cycle(1'b1, $urandom(), 1'b1, rnd_upd());
        repeat (20) cycle(1'b1, $urandom(), 1'b0, rnd_upd());

        // Fill the FIFO to full under continuous lookups, then drain
        repeat (40) cycle(1'b1, $urandom(), 1'b1, rnd_upd());
        repeat (30) cycle(1'b0, $urandom(), ($urandom_range(0, 1) == 1), rnd_upd());
        idle(LAT + 2);

        // Random mix
        repeat (600) cycle($urandom_range(0, 9) < 7, $urandom(), $urandom_range(0, 9) < 4, rnd_upd());

        // Asynchronous reset in the middle of traffic
        @(negedge clk);
        #2;
        rst = 1'b0;
        lkp_valid_i = 1'b0;
        upd_valid_i = 1'b0;
        model_reset();
        #1;
        check_regs();
        check_readies(1'b1);
        repeat (2) @(posedge clk);
        release_reset();
        idle(LAT + 3);

        repeat (300) cycle($urandom_range(0, 9) < 8, $urandom(), $urandom_range(0, 9) < 5, rnd_upd());
        idle(LAT + 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
